// File: rtl/max2_io_pkg.sv
// Register window layout shared by the MAX II I/O bridge and its sub-blocks.
package max2_io_pkg;

   localparam int WINDOW_SIZE = 16;
   localparam int OFF_BITS    = $clog2(WINDOW_SIZE);

   localparam logic [OFF_BITS-1:0] OFF_LED     = 4'h0;
   localparam logic [OFF_BITS-1:0] OFF_KEYS    = 4'h1;
   localparam logic [OFF_BITS-1:0] OFF_EDGE    = 4'h2;
   localparam logic [OFF_BITS-1:0] OFF_PRESC   = 4'h3;
   localparam logic [OFF_BITS-1:0] OFF_ENABLE  = 4'h4;
   localparam logic [OFF_BITS-1:0] OFF_IRQMASK = 4'h5;
   localparam logic [OFF_BITS-1:0] OFF_DUTY    = 4'h8;

endpackage

// File: rtl/max2_debounce.sv
// Purpose: synchronise and debounce one active-low key; pulses rise on an accepted press.
// Latency: 2 sync clocks plus 2^DEB_BITS stable clocks before the state flips.
// Backpressure: none; free-running per-key state machine.
module max2_debounce #(
   parameter int DEB_BITS = 16
) (
   input  logic clock,
   input  logic reset_n,
   input  logic key,
   output logic pressed,
   output logic rise
);

   logic                sync1;
   logic                sync2;
   logic [DEB_BITS-1:0] cnt;
   logic                flip;

   assign flip = (sync2 != pressed) && (cnt == {DEB_BITS{1'b1}});
   assign rise = flip && !pressed;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         cnt     <= '0;
         pressed <= 1'b0;
      end else begin
         sync1 <= ~key;
         sync2 <= sync1;
         // Any sample matching the accepted state restarts the stability window.
         if (sync2 == pressed) begin
            cnt <= '0;
         end else if (flip) begin
            cnt     <= '0;
            pressed <= ~pressed;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/max2_io.sv
// Purpose: 6502 memory-mapped bridge for LEDs, debounced keys and PWM outputs; IRQ via MAX2_IO_IRQ_EN.
// Latency: reads combinational, writes land on the next clock edge, pwm registered one clock.
// Backpressure: none; the core bus is never stalled.
module max2_io #(
   parameter int                   ADDR_BITS = 15,
   parameter logic [ADDR_BITS-1:0] BASE      = 15'h7F00,
   parameter int                   CHANNELS  = 6,
   parameter int                   PWM_BITS  = 8,
   parameter int                   KEYS      = 4,
   parameter int                   DEB_BITS  = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [ADDR_BITS-1:0] address,
   input  logic [7:0]           wdata,
   input  logic                 we,
   output logic [7:0]           rdata,
   output logic                 hit,
   input  logic [KEYS-1:0]      key,
   output logic [7:0]           led,
   output logic [CHANNELS-1:0]  pwm,
   output logic                 irq
);

   import max2_io_pkg::*;

   logic [OFF_BITS-1:0] off;
   logic                wr_en;
   logic [KEYS-1:0]     deb_state;
   logic [KEYS-1:0]     deb_rise;
   logic [KEYS-1:0]     edge_r;
   logic [KEYS-1:0]     edge_clr;
   logic [7:0]          led_r;
   logic [7:0]          presc_r;
   logic [7:0]          pcnt;
   logic                tick;
   logic [CHANNELS-1:0] enable_r;
   logic [CHANNELS-1:0] pwm_r;
   logic [PWM_BITS-1:0] cnt;
   logic [PWM_BITS-1:0] duty_r [CHANNELS];
   logic [PWM_BITS-1:0] act_r  [CHANNELS];
   logic [7:0]          mask_rd;
   logic [7:0]          rd;

   assign off      = address[OFF_BITS-1:0];
   assign hit      = (address[ADDR_BITS-1:OFF_BITS] == BASE[ADDR_BITS-1:OFF_BITS]);
   assign wr_en    = we && hit;
   assign edge_clr = (wr_en && off == OFF_EDGE) ? wdata[KEYS-1:0] : '0;
   assign tick     = (pcnt == presc_r);
   assign led      = led_r;
   assign pwm      = pwm_r;

   for (genvar k = 0; k < KEYS; k++) begin : g_key
      max2_debounce #(.DEB_BITS(DEB_BITS)) u_deb (
         .clock   (clock),
         .reset_n (reset_n),
         .key     (key[k]),
         .pressed (deb_state[k]),
         .rise    (deb_rise[k])
      );
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         led_r    <= '0;
         edge_r   <= '0;
         presc_r  <= '0;
         pcnt     <= '0;
         enable_r <= '0;
         pwm_r    <= '0;
         cnt      <= '0;
         for (int n = 0; n < CHANNELS; n++) begin
            duty_r[n] <= '0;
            act_r[n]  <= '0;
         end
      end else begin
         if (wr_en && off == OFF_LED)    led_r    <= wdata;
         if (wr_en && off == OFF_PRESC)  presc_r  <= wdata;
         if (wr_en && off == OFF_ENABLE) enable_r <= wdata[CHANNELS-1:0];
         for (int n = 0; n < CHANNELS; n++) begin
            if (wr_en && off[3] && off[2:0] == 3'(n)) duty_r[n] <= wdata[PWM_BITS-1:0];
         end

         // Set is ORed in after the clear so a simultaneous press survives.
         edge_r <= (edge_r & ~edge_clr) | deb_rise;

         // >= also recovers when PRESC is lowered below the running count.
         if (pcnt >= presc_r) pcnt <= '0;
         else                 pcnt <= pcnt + 8'd1;

         if (tick) begin
            cnt <= cnt + 1'b1;
            if (cnt == {PWM_BITS{1'b1}}) begin
               for (int n = 0; n < CHANNELS; n++) act_r[n] <= duty_r[n];
            end
         end

         for (int n = 0; n < CHANNELS; n++) begin
            pwm_r[n] <= enable_r[n] && (cnt < act_r[n]);
         end
      end
   end

`ifdef MAX2_IO_IRQ_EN
   logic [KEYS-1:0] mask_r;
   logic            irq_r;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mask_r <= '0;
         irq_r  <= 1'b0;
      end else begin
         if (wr_en && off == OFF_IRQMASK) mask_r <= wdata[KEYS-1:0];
         irq_r <= |(edge_r & mask_r);
      end
   end

   assign irq = irq_r;

   always_comb begin
      mask_rd = '0;
      mask_rd[KEYS-1:0] = mask_r;
   end
`else
   assign irq     = 1'b0;
   assign mask_rd = '0;
`endif

   always_comb begin
      rd = '0;
      case (off)
         OFF_LED:     rd = led_r;
         OFF_KEYS:    rd[KEYS-1:0] = deb_state;
         OFF_EDGE:    rd[KEYS-1:0] = edge_r;
         OFF_PRESC:   rd = presc_r;
         OFF_ENABLE:  rd[CHANNELS-1:0] = enable_r;
         OFF_IRQMASK: rd = mask_rd;
         default: begin
            for (int n = 0; n < CHANNELS; n++) begin
               if (off[3] && off[2:0] == 3'(n)) rd[PWM_BITS-1:0] = duty_r[n];
            end
         end
      endcase
      rdata = hit ? rd : 8'h00;
   end

endmodule
